dp_ram_stream_reader: RTL and testbench

- PL-side reader that owns port B of the PS/PL dual-port RAM (2-cycle registered read, no read enable).
- Accepts a command (start address, word count) and issues sequential RAM reads.
- Tracks the fixed read latency and returns the words on a valid/ready stream with a last marker.
- Backpressure is absorbed by a small FIFO, so no returned word is ever dropped.

---
 rtl/dp_ram_pkg.sv | 15 +
 rtl/dp_ram_stream_reader_sync_fifo.sv | 73 +++++++
 rtl/dp_ram_stream_reader.sv | 203 ++++++++++++++++++++
 tb/tb_dp_ram_stream_reader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_ram_pkg.sv
// Shared constants and types for the PL-side dual-port RAM reader.
package dp_ram_pkg;

    // Port-B read latency: address in cycle c, data on dout in cycle c+2.
    localparam int RD_LATENCY = 2;

    // Reader control states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } reader_state_t;

endpackage

// File: rtl/dp_ram_stream_reader_sync_fifo.sv
// Small first-word-fall-through FIFO holding {last, data} beats for the
// reader's output stream. Head entry is always visible on pop_data.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap at DEPTH-1 so non-power-of-two depths work too.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == CNT_W'(DEPTH));
    assign count    = count_reg;
    assign pop_data = mem_reg[rd_ptr_reg];
    assign do_pop   = pop && !empty;
    // A push into a full FIFO is only accepted when a pop frees a slot.
    assign do_push  = push && (!full || do_pop);

    // Storage: cleared on reset so the head reads as zero when empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; push+pop leaves count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/dp_ram_stream_reader.sv
// Reader that owns port B of the PS/PL dual-port RAM: takes a
// (start address, length) command, issues sequential reads under a credit
// check, tracks the fixed read latency and returns the words on a
// valid/ready stream with a last marker.
module dp_ram_stream_reader
    import dp_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_wr_en,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    localparam int LEN_W = ADDR_WIDTH + 1;
    localparam int FCW   = $clog2(FIFO_DEPTH + 1);
    localparam int IW    = $clog2(RD_LATENCY + 1);
    localparam int SUM_W = ((FCW > IW) ? FCW : IW) + 1;

    reader_state_t         state_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [LEN_W-1:0]      remaining_reg;
    logic [ADDR_WIDTH-1:0] ram_addr_hold_reg;
    logic                  last_sent_reg;
    logic                  busy_reg;
    logic                  done_reg;
    logic                  cmd_ready_reg;

    logic [RD_LATENCY-1:0] trk_valid_reg;
    logic [RD_LATENCY-1:0] trk_last_reg;
    logic [IW-1:0]         inflight_count;

    logic                  fifo_push;
    logic [DATA_WIDTH:0]   fifo_din;
    logic [DATA_WIDTH:0]   fifo_dout;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FCW-1:0]        fifo_count;

    logic                  credit_ok;
    logic                  issue;
    logic                  issue_last;
    logic                  last_hs;

    // Port B is read-only from this side.
    assign ram_wr_en = 1'b0;
    assign ram_din   = '0;

    // Number of reads whose data has not yet reached the FIFO.
    always_comb begin
        inflight_count = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight_count = inflight_count + IW'(trk_valid_reg[i]);
        end
    end

    // Conservative credit: every outstanding read must already own a FIFO
    // slot, so a stalled consumer can never cause an overflow. fifo_full
    // implies no credit; it is included so the intent is explicit.
    assign credit_ok  = ((SUM_W'(fifo_count) + SUM_W'(inflight_count)) < SUM_W'(FIFO_DEPTH))
                        && !fifo_full;
    assign issue      = (state_reg == ISSUE) && credit_ok;
    assign issue_last = issue && (remaining_reg == LEN_W'(1));

    // The live address goes out on an issue cycle; otherwise hold the last one.
    assign ram_addr   = issue ? addr_reg : ram_addr_hold_reg;

    // In-flight tracker: one stage per cycle of RAM latency, carrying a
    // valid bit and the last marker alongside each read.
    genvar gi;
    generate
        for (gi = 0; gi < RD_LATENCY; gi++) begin : g_trk
            if (gi == 0) begin : g_head
                // First stage captures the read issued this cycle.
                always_ff @(posedge clk) begin
                    if (reset) begin
                        trk_valid_reg[gi] <= 1'b0;
                        trk_last_reg[gi]  <= 1'b0;
                    end else begin
                        trk_valid_reg[gi] <= issue;
                        trk_last_reg[gi]  <= issue_last;
                    end
                end
            end else begin : g_tail
                // Later stages shift the tag along with the RAM pipeline.
                always_ff @(posedge clk) begin
                    if (reset) begin
                        trk_valid_reg[gi] <= 1'b0;
                        trk_last_reg[gi]  <= 1'b0;
                    end else begin
                        trk_valid_reg[gi] <= trk_valid_reg[gi-1];
                        trk_last_reg[gi]  <= trk_last_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    // The final tracker stage lines up with the word on ram_dout.
    assign fifo_push = trk_valid_reg[RD_LATENCY-1];
    assign fifo_din  = {trk_last_reg[RD_LATENCY-1], ram_dout};

    sync_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (fifo_din),
        .pop       (m_valid && m_ready),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign m_valid = !fifo_empty;
    assign m_data  = fifo_dout[DATA_WIDTH-1:0];
    // Gate last with valid so a stale entry never shows a last marker.
    assign m_last  = fifo_dout[DATA_WIDTH] && !fifo_empty;
    assign last_hs = m_valid && m_ready && m_last;

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign cmd_ready = cmd_ready_reg;

    // Command FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= IDLE;
            addr_reg          <= '0;
            remaining_reg     <= '0;
            ram_addr_hold_reg <= '0;
            last_sent_reg     <= 1'b0;
            busy_reg          <= 1'b0;
            done_reg          <= 1'b0;
            cmd_ready_reg     <= 1'b1;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cmd_valid && cmd_ready_reg) begin
                        addr_reg      <= cmd_addr;
                        remaining_reg <= cmd_len;
                        last_sent_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        cmd_ready_reg <= 1'b0;
                        if (cmd_len == '0) begin
                            state_reg <= FINISH;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        ram_addr_hold_reg <= addr_reg;
                        addr_reg          <= addr_reg + ADDR_WIDTH'(1);
                        remaining_reg     <= remaining_reg - LEN_W'(1);
                        if (issue_last) begin
                            state_reg <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (last_hs) begin
                        last_sent_reg <= 1'b1;
                    end
                    if ((trk_valid_reg == '0) && (last_sent_reg || last_hs)) begin
                        state_reg <= FINISH;
                        done_reg  <= 1'b1;
                    end
                end
                FINISH: begin
                    state_reg     <= IDLE;
                    busy_reg      <= 1'b0;
                    cmd_ready_reg <= 1'b1;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dp_ram_stream_reader.sv
// Directed bench for dp_ram_stream_reader with a 2-cycle registered RAM model
// preloaded with word[i] = i. Inputs are driven and outputs checked on the
// falling edge; the DUT samples on the rising edge.
module tb_dp_ram_stream_reader;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_addr;
    logic [10:0] cmd_len;
    logic [9:0]  ram_addr;
    logic        ram_wr_en;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_last;
    logic        busy;
    logic        done;

    int n_pass   = 0;
    int n_checks = 0;

    logic [31:0] ram_mem [1024];
    logic [31:0] ram_stage;

    dp_ram_stream_reader #(
        .ADDR_WIDTH (10),
        .DATA_WIDTH (32),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .ram_addr  (ram_addr),
        .ram_wr_en (ram_wr_en),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-stage registered read port: address in cycle c, data in cycle c+2.
    always @(posedge clk) begin
        ram_stage <= ram_mem[ram_addr];
        ram_dout  <= ram_stage;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    endtask

    // Present a command for one cycle; returns at the cycle after acceptance.
    task automatic send_cmd(input logic [9:0] a, input logic [10:0] l);
        chk("cmd_ready_idle", {63'd0, cmd_ready}, 64'd1);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        nxt();
        cmd_valid = 1'b0;
    endtask

    // Consume beats until done, checking data/last against word[i]=i.
    // Handles the current cycle first; returns in the done cycle.
    task automatic collect(input string tag, input logic [9:0] base, input int len,
                           input int stall, input int budget);
        int          got;
        bit          seen_done;
        logic [9:0]  a;
        got       = 0;
        seen_done = 1'b0;
        for (int c = 0; c < budget && !seen_done; c++) begin
            m_ready = (c >= stall);
            if (m_valid && m_ready) begin
                a = base + got[9:0];
                chk({tag, "_data"}, {32'd0, m_data}, {54'd0, a});
                chk({tag, "_last"}, {63'd0, m_last}, {63'd0, (got == len - 1)});
                got++;
            end
            if (done) seen_done = 1'b1;
            else nxt();
        end
        chk({tag, "_done_seen"}, {63'd0, seen_done}, 64'd1);
        chk({tag, "_beats"}, 64'(got), 64'(len));
    endtask

    logic [9:0] wrap_exp [4];

    initial begin
        for (int i = 0; i < 1024; i++) ram_mem[i] = 32'(i);
        wrap_exp  = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        m_ready   = 1'b0;

        // Reset state
        nxt(); nxt();
        reset = 1'b0;
        nxt();
        chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        chk("rst_m_valid",   {63'd0, m_valid},   64'd0);
        chk("rst_m_last",    {63'd0, m_last},    64'd0);
        chk("rst_busy",      {63'd0, busy},      64'd0);
        chk("rst_done",      {63'd0, done},      64'd0);
        chk("rst_ram_addr",  {54'd0, ram_addr},  64'd0);
        chk("rst_m_data",    {32'd0, m_data},    64'd0);
        chk("rst_wr_en",     {63'd0, ram_wr_en}, 64'd0);
        chk("rst_din",       {32'd0, ram_din},   64'd0);

        // Basic read: addr 0x010, len 4, consumer always ready
        m_ready = 1'b1;
        send_cmd(10'h010, 11'd4);
        for (int k = 1; k <= 9; k++) begin
            if (k <= 4) chk("basic_ram_addr", {54'd0, ram_addr}, 64'(10'h010 + k - 1));
            chk("basic_m_valid", {63'd0, m_valid}, {63'd0, (k >= 4 && k <= 7)});
            if (k >= 4 && k <= 7) begin
                chk("basic_m_data", {32'd0, m_data}, 64'(32'h10 + k - 4));
                chk("basic_m_last", {63'd0, m_last}, {63'd0, (k == 7)});
            end
            chk("basic_done",      {63'd0, done},      {63'd0, (k == 8)});
            chk("basic_busy",      {63'd0, busy},      {63'd0, (k <= 8)});
            chk("basic_cmd_ready", {63'd0, cmd_ready}, {63'd0, (k == 9)});
            if (k < 9) nxt();
        end

        // Command held while busy: A = (0x040, 2), then B = (0x050, 1) held
        chk("busy_cmd_ready_idle", {63'd0, cmd_ready}, 64'd1);
        cmd_valid = 1'b1;
        cmd_addr  = 10'h040;
        cmd_len   = 11'd2;
        nxt();
        cmd_addr  = 10'h050;
        cmd_len   = 11'd1;
        for (int k = 1; k <= 6; k++) begin
            chk("held_cmd_ready", {63'd0, cmd_ready}, 64'd0);
            chk("held_done", {63'd0, done}, {63'd0, (k == 6)});
            if (k == 4 || k == 5) begin
                chk("held_a_data", {32'd0, m_data}, 64'(32'h40 + k - 4));
                chk("held_a_last", {63'd0, m_last}, {63'd0, (k == 5)});
            end
            nxt();
        end
        chk("held_accept_ready", {63'd0, cmd_ready}, 64'd1);
        nxt();
        cmd_valid = 1'b0;
        chk("held_b_busy", {63'd0, busy}, 64'd1);
        chk("held_b_ram_addr", {54'd0, ram_addr}, 64'h050);
        collect("held_b", 10'h050, 1, 0, 40);
        nxt();

        // Backpressure: len 8, consumer stalled for 16 cycles
        m_ready = 1'b0;
        send_cmd(10'h020, 11'd8);
        for (int k = 1; k <= 15; k++) begin
            chk("bp_addr_bound", {63'd0, (ram_addr <= 10'h023)}, 64'd1);
            if (k >= 4) begin
                chk("bp_m_valid", {63'd0, m_valid}, 64'd1);
                chk("bp_m_data_stable", {32'd0, m_data}, 64'h20);
                chk("bp_m_last", {63'd0, m_last}, 64'd0);
            end
            if (k == 15) chk("bp_issued_four", {54'd0, ram_addr}, 64'h023);
            nxt();
        end
        collect("bp", 10'h020, 8, 0, 60);
        nxt();

        // Wrap-around: 0x3FE, len 4
        m_ready = 1'b1;
        send_cmd(10'h3FE, 11'd4);
        for (int k = 1; k <= 4; k++) begin
            chk("wrap_ram_addr", {54'd0, ram_addr}, {54'd0, wrap_exp[k-1]});
            if (k < 4) nxt();
        end
        collect("wrap", 10'h3FE, 4, 0, 40);
        nxt();

        // Zero length
        send_cmd(10'h123, 11'd0);
        chk("zero_done",    {63'd0, done},    64'd1);
        chk("zero_busy",    {63'd0, busy},    64'd1);
        chk("zero_m_valid", {63'd0, m_valid}, 64'd0);
        nxt();
        chk("zero_done_after",  {63'd0, done},      64'd0);
        chk("zero_busy_after",  {63'd0, busy},      64'd0);
        chk("zero_ready_after", {63'd0, cmd_ready}, 64'd1);
        chk("zero_m_valid_after", {63'd0, m_valid}, 64'd0);

        // Reset in the middle of a len-8 read, then a fresh len-2 command
        send_cmd(10'h080, 11'd8);
        nxt(); nxt(); nxt(); nxt();
        reset = 1'b1;
        nxt();
        reset = 1'b0;
        chk("mid_rst_m_valid",   {63'd0, m_valid},   64'd0);
        chk("mid_rst_busy",      {63'd0, busy},      64'd0);
        chk("mid_rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        chk("mid_rst_done",      {63'd0, done},      64'd0);
        chk("mid_rst_ram_addr",  {54'd0, ram_addr},  64'd0);
        chk("mid_rst_m_data",    {32'd0, m_data},    64'd0);
        send_cmd(10'h090, 11'd2);
        collect("post_rst", 10'h090, 2, 0, 40);
        nxt();

        // Full-RAM length starting mid-array, wrapping once
        send_cmd(10'h3F0, 11'd1024);
        collect("full", 10'h3F0, 1024, 0, 1200);
        nxt();
        chk("full_idle_ready", {63'd0, cmd_ready}, 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
